// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider for DIV / DIVU in the EX stage.
//
// Ports:
//   clk          - clock, all state changes on the rising edge
//   rst          - synchronous active-high reset
//   start_i      - division request, level-held until the result is consumed
//   annul_i      - cancel an in-flight or pending division (flush / exception)
//   signed_div_i - 1: DIV (two's complement), 0: DIVU
//   opdata1_i    - dividend (rs)
//   opdata2_i    - divisor (rt)
//   result_o     - {remainder, quotient}, registered
//   ready_o      - result valid, registered
module div_unit #(
    parameter int unsigned DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  annul_i,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o
);

    localparam int unsigned WorkW = 2 * DATA_W + 1;
    localparam int unsigned CntW  = $clog2(DATA_W);
    localparam logic [CntW-1:0] LastCnt = CntW'(DATA_W - 1);

    typedef enum logic [1:0] {StFree, StZero, StOn, StEnd} state_e;

    state_e                state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [WorkW-1:0]      work_q, work_d;
    logic [DATA_W-1:0]     divisor_q, divisor_d;
    logic                  sign_q_q, sign_q_d;   // quotient sign
    logic                  sign_r_q, sign_r_d;   // remainder sign (dividend sign)
    logic [2*DATA_W-1:0]   result_q, result_d;
    logic                  ready_q, ready_d;

    logic                  accept;
    logic                  neg1, neg2;
    logic [DATA_W-1:0]     abs1, abs2;
    logic [DATA_W:0]       diff;
    logic [WorkW-1:0]      work_step;
    logic [DATA_W-1:0]     quo_mag, rem_mag;

    assign accept = start_i && !annul_i;

    // Operand magnitudes, only meaningful on the acceptance edge.
    assign neg1 = signed_div_i && opdata1_i[DATA_W-1];
    assign neg2 = signed_div_i && opdata2_i[DATA_W-1];
    assign abs1 = neg1 ? (~opdata1_i + 1'b1) : opdata1_i;
    assign abs2 = neg2 ? (~opdata2_i + 1'b1) : opdata2_i;

    // One restoring step. Partial remainder in work[64:32] is always < 2*divisor,
    // so bit DATA_W of diff is a reliable borrow flag.
    assign diff      = work_q[WorkW-1:DATA_W] - {1'b0, divisor_q};
    assign work_step = diff[DATA_W] ? {work_q[WorkW-2:0], 1'b0}
                                    : {diff[DATA_W-1:0], work_q[DATA_W-1:0], 1'b1};
    assign quo_mag   = work_step[DATA_W-1:0];
    assign rem_mag   = work_step[WorkW-1:DATA_W+1];

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StFree;
            cnt_q     <= '0;
            work_q    <= '0;
            divisor_q <= '0;
            sign_q_q  <= 1'b0;
            sign_r_q  <= 1'b0;
            result_q  <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            work_q    <= work_d;
            divisor_q <= divisor_d;
            sign_q_q  <= sign_q_d;
            sign_r_q  <= sign_r_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFree: begin
                if (accept) begin
                    state_d = (opdata2_i == '0) ? StZero : StOn;
                end
            end
            StZero:  state_d = annul_i ? StFree : StEnd;
            StOn: begin
                if (annul_i) begin
                    state_d = StFree;
                end else if (cnt_q == LastCnt) begin
                    state_d = StEnd;
                end
            end
            StEnd:   state_d = start_i ? StEnd : StFree;
            default: state_d = StFree;
        endcase
    end

    // Datapath and output next values.
    always_comb begin
        cnt_d     = cnt_q;
        work_d    = work_q;
        divisor_d = divisor_q;
        sign_q_d  = sign_q_q;
        sign_r_d  = sign_r_q;
        result_d  = result_q;
        ready_d   = ready_q;
        unique case (state_q)
            StFree: begin
                cnt_d    = '0;
                result_d = '0;
                ready_d  = 1'b0;
                if (accept && (opdata2_i != '0)) begin
                    divisor_d = abs2;
                    work_d    = {{DATA_W{1'b0}}, abs1, 1'b0};
                    sign_q_d  = neg1 ^ neg2;
                    sign_r_d  = neg1;
                end
            end
            StZero: begin
                result_d = '0;
                ready_d  = !annul_i;
            end
            StOn: begin
                if (annul_i) begin
                    cnt_d    = '0;
                    result_d = '0;
                    ready_d  = 1'b0;
                end else begin
                    work_d = work_step;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == LastCnt) begin
                        result_d = {sign_r_q ? (~rem_mag + 1'b1) : rem_mag,
                                    sign_q_q ? (~quo_mag + 1'b1) : quo_mag};
                        ready_d  = 1'b1;
                    end
                end
            end
            StEnd: begin
                if (!start_i) begin
                    result_d = '0;
                    ready_d  = 1'b0;
                end
            end
            default: begin
                result_d = '0;
                ready_d  = 1'b0;
            end
        endcase
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule
